mem_arbiter: RTL and testbench

- Shares the single-port simulation memory `MemoryUnit` between two requesters:
  - port 0: instruction fetch;
  - port 1: load/store unit.
- Two-way round-robin arbitration; one transaction in flight at a time.
- Reads are sequenced through registered states, so the combinational memory read path is sampled at a defined edge.
- Optionally performs read-modify-write to give byte/halfword stores on a word-write memory.

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/mem_arb_rr.sv | 24 ++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, constants and byte-merge helper for mem_arbiter
// MEM_ARB_RMW_EN adds the RMW_RD state used for partial-strobe writes.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
`ifdef MEM_ARB_RMW_EN
    RMW_RD = 3'd4,
`endif
    READ   = 3'd1,
    WRITE  = 3'd2,
    RESP   = 3'd3
  } mem_arb_state_t;

  typedef logic port_t;

  localparam logic [3:0] STRB_FULL = 4'hF;
  localparam port_t      PORT_IF   = 1'b0;
  localparam port_t      PORT_LS   = 1'b1;

  // Strobe bit i selects lane [8i+7:8i]; bit 3 is the byte at addr+0.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and MemoryUnit signals of mem_arbiter
// slave is the arbiter side; master is the requesters plus the memory model.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              m0_req,    m1_req;
  logic              m0_we,     m1_we;
  logic [ADDR_W-1:0] m0_addr,   m1_addr;
  logic [DATA_W-1:0] m0_wdata,  m1_wdata;
  logic [STRB_W-1:0] m0_wstrb,  m1_wstrb;
  logic              m0_gnt,    m1_gnt;
  logic              m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata,  m1_rdata;

  logic              mem_write_enable;
  logic [ADDR_W-1:0] mem_read_addr;
  logic [ADDR_W-1:0] mem_write_addr;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              busy;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_write_enable, mem_read_addr, mem_write_addr, mem_write_data,
    input  mem_read_data,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_write_enable, mem_read_addr, mem_write_addr, mem_write_data,
    output mem_read_data,
    input  busy
  );

endinterface

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - combinational two-way round-robin picker; last_grant lives in mem_arbiter
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last_grant,
  output logic [1:0] gnt,
  output port_t      sel
);

  always_comb begin
    sel = PORT_IF;
    if (req == 2'b11) begin
      sel = (last_grant == PORT_IF) ? PORT_LS : PORT_IF;
    end else if (req[1]) begin
      sel = PORT_LS;
    end
    gnt = 2'b00;
    if (req != 2'b00) begin
      gnt = (sel == PORT_LS) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin sharing of a single-port MemoryUnit between fetch and load/store
// MEM_ARB_RMW_EN: partial-strobe writes are read-modify-write through RMW_RD.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int STRB_W = DATA_W / 8;

  mem_arb_state_t    state;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [STRB_W-1:0] wstrb_q;
  port_t             port_q;
  port_t             last_grant;

  logic [1:0]        req;
  logic [1:0]        rr_gnt;
  port_t             sel;
  logic              grant;
  logic              resp;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;

  assign req = {bus.m1_req, bus.m0_req};

  mem_arb_rr u_rr (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (rr_gnt),
    .sel        (sel)
  );

  assign grant      = (state == IDLE) && !reset && (req != 2'b00);
  assign bus.m0_gnt = grant && rr_gnt[0];
  assign bus.m1_gnt = grant && rr_gnt[1];

  assign sel_we    = (sel == PORT_LS) ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = (sel == PORT_LS) ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = (sel == PORT_LS) ? bus.m1_wdata : bus.m0_wdata;
  assign sel_wstrb = (sel == PORT_LS) ? bus.m1_wstrb : bus.m0_wstrb;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      port_q     <= PORT_IF;
      last_grant <= PORT_LS;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            addr_q     <= sel_addr;
            we_q       <= sel_we;
            wdata_q    <= sel_wdata;
            wstrb_q    <= sel_wstrb;
            port_q     <= sel;
            last_grant <= sel;
            if (!sel_we) begin
              state <= READ;
`ifdef MEM_ARB_RMW_EN
            end else if (sel_wstrb != STRB_FULL && sel_wstrb != '0) begin
              state <= RMW_RD;
`endif
            end else begin
              state <= WRITE;
            end
          end
        end
        READ: begin
          rdata_q <= bus.mem_read_data;
          state   <= RESP;
        end
`ifdef MEM_ARB_RMW_EN
        RMW_RD: begin
          wdata_q <= merge_bytes(bus.mem_read_data, wdata_q, wstrb_q);
          state   <= WRITE;
        end
`endif
        WRITE:   state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Read and write share addr_q; the memory only acts on write_enable.
  assign bus.mem_read_addr    = addr_q;
  assign bus.mem_write_addr   = addr_q;
  assign bus.mem_write_data   = wdata_q;
  assign bus.mem_write_enable = (state == WRITE) && (wstrb_q != '0) && !reset;

  assign resp          = (state == RESP) && !reset;
  assign bus.m0_rvalid = resp && (port_q == PORT_IF);
  assign bus.m1_rvalid = resp && (port_q == PORT_LS);
  assign bus.m0_rdata  = (bus.m0_rvalid && !we_q) ? rdata_q : '0;
  assign bus.m1_rdata  = (bus.m1_rvalid && !we_q) ? rdata_q : '0;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter, follows MEM_ARB_RMW_EN when defined
module tb_mem_arbiter;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic mem_init = 1'b1;
  int   checks    = 0;
  int   errors    = 0;
  int   wen_count = 0;
  int   ep_id     = 0;
  bit   rr_last   = 1'b1;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

`ifdef MEM_ARB_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // Byte-addressed memory, big-endian lanes, 8-bit wrap.
  logic [7:0] ra, wa;
  assign ra = bus.mem_read_addr[7:0];
  assign wa = bus.mem_write_addr[7:0];
  assign bus.mem_read_data = {mem[ra], mem[ra + 8'd1], mem[ra + 8'd2], mem[ra + 8'd3]};

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
    end else if (bus.mem_write_enable) begin
      mem[wa]        <= bus.mem_write_data[31:24];
      mem[wa + 8'd1] <= bus.mem_write_data[23:16];
      mem[wa + 8'd2] <= bus.mem_write_data[15:8];
      mem[wa + 8'd3] <= bus.mem_write_data[7:0];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clock);
    if (bus.mem_write_enable) wen_count++;
    if (!mem_init) begin
      check("gnt_exclusive", 32'(bus.m0_gnt & bus.m1_gnt), 32'd0);
      check("rvalid_exclusive", 32'(bus.m0_rvalid & bus.m1_rvalid), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_port(input bit p, input bit req, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
    if (p) begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_wstrb = strb;
    end else begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_wstrb = strb;
    end
  endtask

  task automatic set_req(input bit p, input bit req);
    if (p) bus.m1_req = req;
    else   bus.m0_req = req;
  endtask

  function automatic bit gnt_of(input bit p);
    return p ? bus.m1_gnt : bus.m0_gnt;
  endfunction

  function automatic bit rv_of(input bit p);
    return p ? bus.m1_rvalid : bus.m0_rvalid;
  endfunction

  function automatic logic [31:0] rd_of(input bit p);
    return p ? bus.m1_rdata : bus.m0_rdata;
  endfunction

  // Reference model: byte-addressed memory plus strobe and latency rules.
  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {ref_mem[b], ref_mem[b + 8'd1], ref_mem[b + 8'd2], ref_mem[b + 8'd3]};
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] wdata, input logic [3:0] strb);
    logic [7:0] b;
    for (int k = 0; k < 4; k++) begin
      b = 8'(a[7:0] + k);
      if (RMW ? strb[3-k] : (strb != 4'h0)) ref_mem[b] = wdata[31-8*k -: 8];
    end
  endtask

  function automatic int ref_lat(input bit we, input logic [3:0] strb);
    return (we && RMW && strb != 4'h0 && strb != 4'hF) ? 3 : 2;
  endfunction

  task automatic ref_txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] strb, output logic [31:0] rd);
    if (we) begin
      ref_write(a, wd, strb);
      rd = 32'h0;
    end else begin
      rd = ref_word(a);
    end
  endtask

  task automatic run_one(input bit p, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, output logic [31:0] rdata, output int lat,
                         output int wen, output int other, output bit first_gnt);
    int tg;
    int w0;
    tg = -1; lat = -1; rdata = 32'hxxxxxxxx; other = 0; first_gnt = 1'b0;
    w0 = wen_count;
    set_port(p, 1'b1, we, addr, wdata, strb);
    for (int k = 0; k < 12 && lat < 0; k++) begin
      @(negedge clock);
      if (rv_of(!p)) other++;
      if (tg < 0) begin
        if (gnt_of(p)) begin
          tg = k;
          first_gnt = (k == 0);
        end
      end else if (rv_of(p)) begin
        lat   = k - tg;
        rdata = rd_of(p);
      end
      tick();
      if (tg >= 0) set_req(p, 1'b0);
    end
    wen = wen_count - w0;
  endtask

  task automatic episode(input logic [1:0] mask, input logic [1:0] we,
                         input logic [31:0] ad0, input logic [31:0] ad1,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input logic [3:0] st0, input logic [3:0] st1);
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  st [2];
    logic [31:0] exp_rd [2];
    int exp_lat [2];
    int order [2];
    int tg [2];
    int nact, ngr, nrv;
    ad = '{ad0, ad1}; wd = '{wd0, wd1}; st = '{st0, st1};
    exp_rd = '{32'h0, 32'h0}; exp_lat = '{0, 0};
    if (mask == 2'b11) begin
      order[0] = rr_last ? 0 : 1;
      order[1] = 1 - order[0];
      nact = 2;
    end else begin
      order[0] = mask[1] ? 1 : 0;
      order[1] = -1;
      nact = 1;
    end
    for (int j = 0; j < nact; j++) begin
      ref_txn(we[order[j]], ad[order[j]], wd[order[j]], st[order[j]], exp_rd[order[j]]);
      exp_lat[order[j]] = ref_lat(we[order[j]], st[order[j]]);
    end
    rr_last = 1'(order[nact-1]);
    for (int p = 0; p < 2; p++) begin
      if (mask[p]) set_port(1'(p), 1'b1, we[p], ad[p], wd[p], st[p]);
    end
    ngr = 0; nrv = 0; tg = '{-1, -1};
    for (int k = 0; k < 20 && nrv < nact; k++) begin
      @(negedge clock);
      for (int p = 0; p < 2; p++) begin
        if (gnt_of(1'(p))) begin
          check($sformatf("ep%0d_gnt_order", ep_id), p, (ngr < nact) ? order[ngr] : -1);
          ngr++;
          tg[p] = k;
        end
        if (rv_of(1'(p))) begin
          check($sformatf("ep%0d_p%0d_latency", ep_id, p), k - tg[p], exp_lat[p]);
          check($sformatf("ep%0d_p%0d_rdata", ep_id, p), rd_of(1'(p)), exp_rd[p]);
          nrv++;
        end
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        if (tg[p] >= 0) set_req(1'(p), 1'b0);
      end
    end
    check($sformatf("ep%0d_complete", ep_id), nrv, nact);
    ep_id++;
  endtask

  task automatic wait_idle(input string name);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 10 && !idle; k++) begin
      @(negedge clock);
      idle = !bus.busy;
      tick();
    end
    check(name, 32'(idle), 32'd1);
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_wen;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] rd;
    int lat, wen, other, ng;
    bit g0;
    int gp [3];
    int gc [3];
    logic [3:0] s [2];

    vecs[0] = '{1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2, 1};
    vecs[1] = '{1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 2, 0};
    vecs[2] = '{1'b1, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 2, 1};
    vecs[3] = '{1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11223344, 2, 0};
    vecs[4] = '{1'b1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0100, 32'h0, RMW ? 3 : 2, 1};
    vecs[5] = '{1'b0, 1'b0, 32'h20, 32'h0, 4'h0, RMW ? 32'h11BB3344 : 32'hAABBCCDD, 2, 0};
    vecs[6] = '{1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 2, 0};
    vecs[7] = '{1'b0, 1'b0, 32'h20, 32'h0, 4'h0, RMW ? 32'h11BB3344 : 32'hAABBCCDD, 2, 0};
    vecs[8] = '{1'b1, 1'b0, 32'h21, 32'h0, 4'h0, RMW ? 32'hBB3344FF : 32'hBBCCDDFF, 2, 0};
    vecs[9] = '{1'b0, 1'b0, 32'h00, 32'h0, 4'h0, 32'h030A1118, 2, 0};

    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // A request held during reset must not be granted.
    bus.m0_req = 1'b1;
    repeat (3) tick();
    mem_init = 1'b0;
    @(negedge clock);
    check("rst_m0_gnt", 32'(bus.m0_gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
    check("rst_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    check("rst_mem_we", 32'(bus.mem_write_enable), 32'd0);
    check("rst_read_addr", bus.mem_read_addr, 32'h0);
    check("rst_write_data", bus.mem_write_data, 32'h0);
    check("rst_m0_rdata", bus.m0_rdata, 32'h0);
    tick();
    bus.m0_req = 1'b0;
    reset = 1'b0;

    // Tie after reset with both requests held: m0, m1, m0, three cycles apart.
    gp = '{9, 9, 9}; gc = '{0, 0, 0}; ng = 0;
    set_port(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    set_port(1'b1, 1'b1, 1'b0, 32'h00, 32'h0, 4'h0);
    for (int k = 0; k < 20 && ng < 3; k++) begin
      @(negedge clock);
      if (bus.m0_gnt) begin gp[ng] = 0; gc[ng] = k; ng++; end
      else if (bus.m1_gnt) begin gp[ng] = 1; gc[ng] = k; ng++; end
      tick();
    end
    set_req(1'b0, 1'b0);
    set_req(1'b1, 1'b0);
    check("tie_grants", ng, 3);
    check("tie_first_port", gp[0], 0);
    check("tie_first_cycle", gc[0], 0);
    check("tie_second_port", gp[1], 1);
    check("tie_third_port", gp[2], 0);
    check("tie_gap1", gc[1] - gc[0], 3);
    check("tie_gap2", gc[2] - gc[1], 3);
    wait_idle("tie_idle");

    for (int i = 0; i < 10; i++) begin
      run_one(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, lat, wen, other, g0);
      if (vecs[i].we) ref_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      rr_last = vecs[i].port;
      check($sformatf("vec%0d_gnt", i), 32'(g0), 32'd1);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_write_enables", i), wen, vecs[i].exp_wen);
      check($sformatf("vec%0d_other_rvalid", i), other, 0);
    end

    // Reset during the WRITE cycle drops the transaction without a write or rvalid.
    set_port(1'b1, 1'b1, 1'b1, 32'h30, 32'h55667788, 4'hF);
    @(negedge clock);
    check("rstw_gnt", 32'(bus.m1_gnt), 32'd1);
    tick();
    set_req(1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    check("rstw_mem_we", 32'(bus.mem_write_enable), 32'd0);
    check("rstw_rvalid", 32'(bus.m1_rvalid), 32'd0);
    tick();
    reset = 1'b0;
    rr_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("rstw_busy%0d", k), 32'(bus.busy), 32'd0);
      check($sformatf("rstw_m0_rvalid%0d", k), 32'(bus.m0_rvalid), 32'd0);
      check($sformatf("rstw_m1_rvalid%0d", k), 32'(bus.m1_rvalid), 32'd0);
      tick();
    end
    episode(2'b11, 2'b00, 32'h30, 32'h2C, 32'h0, 32'h0, 4'h0, 4'h0);

    for (int n = 0; n < 60; n++) begin
      for (int p = 0; p < 2; p++) begin
        case ($urandom_range(0, 3))
          0:       s[p] = 4'hF;
          1:       s[p] = 4'h0;
          default: s[p] = 4'($urandom);
        endcase
      end
      episode(2'($urandom_range(1, 3)), 2'($urandom), $urandom, $urandom, $urandom, $urandom, s[0], s[1]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
